// File: rtl/ddr_rpath_pkg.sv
// ddr_rpath_pkg: shared state encodings and read-FIFO word layout for the DDR read path
package ddr_rpath_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rpath_state_e;

    function automatic int rfifo_width(input int dq_width);
        return 2 * dq_width + 1;
    endfunction

    function automatic int rfifo_last_bit(input int dq_width);
        return 2 * dq_width;
    endfunction

endpackage

// File: rtl/ddr_rfifo.sv
// ddr_rfifo: single-clock show-ahead FIFO with full/empty/level; a full FIFO still accepts a push paired with a pop
module ddr_rfifo #(
    parameter int WIDTH = 33,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    // occupancy flags, enables and next pointers; head reads as zero while empty
    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        empty    = level == '0;
        full     = level[AW];
        rd_en    = pop & ~empty;
        wr_en    = push & (~full | rd_en);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
        pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // storage array needs no reset; contents are only visible while non-empty
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    // pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ddr_rpath.sv
// ddr_rpath: DDR read data path - sample alignment, burst framing stage and read FIFO
// Optional burst/drop counters are enabled with `define DDR_RPATH_STATS_EN.
module ddr_rpath
    import ddr_rpath_pkg::*;
#(
    parameter int DQ_WIDTH     = 16,
    parameter int FIFO_AW      = 4,
    parameter int SAMPLE_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample,
    input  logic [DQ_WIDTH-1:0]   dq_rise,
    input  logic [DQ_WIDTH-1:0]   dq_fall,
    output logic [2*DQ_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [FIFO_AW:0]      rd_level,
    output logic                  rd_overflow,
    input  logic                  overflow_clr
`ifdef DDR_RPATH_STATS_EN
    ,
    output logic [15:0]           burst_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int RW       = rfifo_width(DQ_WIDTH);
    localparam int LAST_BIT = rfifo_last_bit(DQ_WIDTH);

    logic                  samp_dly;
    rpath_state_e          state_q, state_d;
    logic [2*DQ_WIDTH-1:0] stage_q, stage_d;
    logic                  ovf_q, ovf_d;
    logic                  push, push_last, pop_fire, drop;
    logic                  fifo_full, fifo_empty;
    logic [RW-1:0]         fifo_head;

    generate
        if (SAMPLE_DELAY == 0) begin : g_nodly
            assign samp_dly = sample;
        end else begin : g_dly
            logic [SAMPLE_DELAY-1:0] dly_q, dly_d;
            // shift sample through SAMPLE_DELAY flops so it lines up with the capture pipeline
            always_comb begin
                dly_d[0] = sample;
                for (int i = 1; i < SAMPLE_DELAY; i++) dly_d[i] = dly_q[i-1];
            end
            // delay line register
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) dly_q <= '0;
                else          dly_q <= dly_d;
            end
            assign samp_dly = dly_q[SAMPLE_DELAY-1];
        end
    endgenerate

    // framing FSM: the staged word is pushed one cycle later, marked last when the sample run ends
    always_comb begin
        state_d   = samp_dly ? HOLD : IDLE;
        stage_d   = samp_dly ? {dq_fall, dq_rise} : stage_q;
        push      = state_q == HOLD;
        push_last = ~samp_dly;
        pop_fire  = ~fifo_empty & rd_ready;
        drop      = push & fifo_full & ~pop_fire;
        ovf_d     = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    end

    // stage, state and sticky overflow registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            ovf_q   <= ovf_d;
        end
    end

    ddr_rfifo #(
        .WIDTH (RW),
        .AW    (FIFO_AW)
    ) u_rfifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({push_last, stage_q}),
        .pop       (rd_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (rd_level)
    );

    assign rd_data     = fifo_head[LAST_BIT-1:0];
    assign rd_last     = fifo_head[LAST_BIT];
    assign rd_valid    = ~fifo_empty;
    assign rd_overflow = ovf_q;

`ifdef DDR_RPATH_STATS_EN
    logic [15:0] burst_cnt_q, burst_cnt_d, drop_cnt_q, drop_cnt_d;
    logic        burst_inc;

    // counters clear on overflow_clr, but a same-cycle increment wins and restarts at 1
    always_comb begin
        burst_inc   = push & push_last;
        burst_cnt_d = burst_inc ? (overflow_clr ? 16'd1 : burst_cnt_q + 16'd1)
                                : (overflow_clr ? 16'd0 : burst_cnt_q);
        drop_cnt_d  = drop ? (overflow_clr ? 16'd1 : drop_cnt_q + 16'd1)
                           : (overflow_clr ? 16'd0 : drop_cnt_q);
    end

    // statistics registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign burst_cnt = burst_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: doc/ddr_rpath.md
Name: ddr_rpath

Overview:
Read data-path of the Wishbone DDR controller, the receive-side counterpart of the write path.
- Takes DQ words already captured by the IOB DDR input flops (rise/fall halves) and the `sample` strobe from the write path's read shift register.
- Aligns `sample` to the capture pipeline and frames each read burst with a last flag.
- Buffers words in a single-clock FIFO drained by the Wishbone front-end through a valid/ready handshake.

Parameters:
- DQ_WIDTH, 16, width of one DDR beat (one edge of DQ).
- FIFO_AW, 4, log2 of read FIFO depth (default 16 entries).
- SAMPLE_DELAY, 2, cycles `sample` is delayed before qualifying capture (0..7; 0 means `sample` is used directly).

Ports:
- clk  in  1  controller clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- sample  in  1  capture qualifier from the write path; high one cycle per beat pair.
- dq_rise  in  DQ_WIDTH  DQ captured on rising DQS edge.
- dq_fall  in  DQ_WIDTH  DQ captured on falling DQS edge.
- rd_data  out  2*DQ_WIDTH  FIFO head word, {fall, rise}; rise occupies the low half.
- rd_last  out  1  head word is the last word of its burst.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer pops the head when rd_valid & rd_ready.
- rd_level  out  FIFO_AW+1  current FIFO occupancy.
- rd_overflow  out  1  sticky: at least one word was dropped.
- overflow_clr  in  1  clears rd_overflow.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - rd_valid=0, rd_last=0, rd_data=0, rd_level=0, rd_overflow=0.
  - Stage empty, sample delay line all 0.
- Delay line: `samp_d` is `sample` delayed by exactly SAMPLE_DELAY clk edges.
- Capture: on an edge where samp_d=1, {dq_fall, dq_rise} is loaded into the one-word stage register.
- FSM states:
  - IDLE (stage empty):
    - samp_d=1 → load stage, go to HOLD.
    - Otherwise stay.
  - HOLD (stage full):
    - samp_d=1 → push stage word with last=0, load new word, stay in HOLD.
    - samp_d=0 → push stage word with last=1, go to IDLE.
- Burst framing:
  - A burst is a maximal run of consecutive samp_d=1 cycles; a 1-cycle run yields a single word with last=1.
  - Back-to-back bursts separated by one idle cycle stay correctly delimited.
- Latency: a word captured at edge t is pushed at edge t+1 and is visible on rd_data/rd_valid after edge t+1, provided the FIFO was empty.
- FIFO:
  - Show-ahead: rd_data/rd_last are valid whenever rd_valid=1.
  - Width is 2*DQ_WIDTH+1 (data plus last); depth is 2^FIFO_AW.
  - Pointers wrap modulo depth; rd_level tracks push minus pop.
- Push/pop boundary rules:
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Any other push while full drops the word, leaves FIFO contents and rd_level unchanged, and sets rd_overflow.
  - Pop when empty is ignored.
  - Simultaneous push and pop leaves rd_level unchanged.
- rd_overflow: cleared by overflow_clr. If a drop occurs in the same cycle as overflow_clr, the set wins.
- Reset mid-burst: stage and FIFO are discarded; the first samp_d after release starts a new burst.

Optional Feature:
- Macro: DDR_RPATH_STATS_EN.
- When defined, adds two outputs:
  - burst_cnt (16 bit): increments on every pushed word with last=1, including dropped words.
  - drop_cnt (16 bit): increments on every dropped word.
  - Both counters wrap at 2^16, reset to 0, and are cleared by overflow_clr (an increment in the same cycle wins and yields 1).
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- ddr_include.v gains:
  - `RFIFO_WIDTH` and `RFIFO_RNG` (2*DQ_WIDTH+1).
  - `RFIFO_D_RNG` and `RFIFO_LAST_BIT` field ranges.
  - The IDLE/HOLD state encodings.
- One sub-module: ddr_rfifo, a single-clock show-ahead FIFO with full/empty/level, parameterised by width and FIFO_AW.
- Stage, FSM, delay line and stats remain in ddr_rpath.

Test Plan:
- Single burst, SAMPLE_DELAY=2: sample high 4 cycles, rise=16'h1000+n, fall=16'h2000+n.
  - Expect 4 words {2000+n,1000+n} in order, last only on the 4th.
  - First rd_valid exactly 4 edges (SAMPLE_DELAY+2) after sample first rises.
- Single-beat burst: sample high 1 cycle → one word with rd_last=1, rd_level=1.
- Back-to-back bursts: sample pattern 1,1,0,1,1,1 → last=1 on words 2 and 5 only.
- Overflow: rd_ready=0, 20 beats with FIFO_AW=4.
  - rd_level saturates at 16, words 17-20 are dropped, rd_overflow=1.
  - Draining returns words 1-16 intact.
  - overflow_clr then clears rd_overflow.
- Full with concurrent pop: FIFO at 16, rd_ready=1, push the same cycle → word accepted, rd_level stays 16, no overflow.
- Reset mid-burst: assert reset_n=0 during the 3rd beat.
  - Outputs go to 0 immediately.
  - After release, a 2-beat burst yields exactly 2 words.
  - With DDR_RPATH_STATS_EN, burst_cnt=1 after that burst.
